pump_input_conditioner: RTL and testbench
=========================================

// Module: pump_input_conditioner
// PURPOSE
//   Front-end stage for the fuel-pump interlock. Synchronises and debounces the
//   three raw driver inputs: ignition key, hidden kill switch and brake pedal.
//   Drives the clean ignition/switch/brake levels that the fuel-pump FSM consumes.
//   Also produces one-cycle rise/fall pulses for alarm and status logic.
// PARAMETERS
//   SYNC_STAGES      2   flip-flops per synchroniser chain (>=2)
//   DEBOUNCE_CYCLES  16  consecutive disagreeing cycles needed to accept a new level (>=2)
// PORTS
//   clock          in   1  single system clock, all logic on posedge
//   reset          in   1  synchronous, active-low reset (0 = reset), sampled on posedge clock
//   ignition_raw   in   1  asynchronous key contact
//   switch_raw     in   1  asynchronous hidden switch contact
//   brake_raw      in   1  asynchronous brake pedal contact
//   ignition       out  1  debounced ignition level
//   switch         out  1  debounced hidden-switch level
//   brake          out  1  debounced brake level
//   rise           out  3  1-cycle pulse on accepted 0->1; [0]=ignition [1]=switch [2]=brake
//   fall           out  3  1-cycle pulse on accepted 1->0; same bit order
// BEHAVIOUR
//   - Reset (reset==0 at a posedge): every sync flop, stable level, counter and
//     pulse clears to 0. All outputs read 0 in the cycle after that edge, so the
//     pump stays OFF. Any count in progress is discarded.
//   - Three identical, fully independent channels. No cross-channel interaction.
//   - Per channel: raw -> SYNC_STAGES flop chain -> s (last stage).
//     stable = registered output level. cnt width = $clog2(DEBOUNCE_CYCLES).
//   - Per-channel FSM, evaluated on every posedge clock:
//       STABLE : s==stable -> stay, cnt=0.
//                s!=stable -> PENDING, cnt=1.
//       PENDING: s==stable -> STABLE, cnt=0. Glitch rejected, no pulse.
//                s!=stable and cnt<DEBOUNCE_CYCLES-1 -> cnt+1.
//                s!=stable and cnt==DEBOUNCE_CYCLES-1 -> stable<=s, cnt=0, STABLE.
//                Fire rise (s=1) or fall (s=0) on this same edge.
//   - Latency: let raw change before posedge E0, the first edge that captures it.
//     stable flips at edge E0+SYNC_STAGES+DEBOUNCE_CYCLES-1 (E0+17 at defaults).
//   - Pulses are registered. They are high for exactly one cycle after the flip
//     edge and low otherwise. rise and fall are never both set on one bit.
//   - Any disagreement lasting fewer than DEBOUNCE_CYCLES consecutive sampled
//     cycles never changes the output.
//   - A channel that toggles every cycle never reaches the threshold.
//   - cnt never wraps: it is cleared at the threshold or on agreement.
//   - Reset released with raw=1: the channel starts from 0 and rises after full latency.
//   - Reset asserted mid-PENDING: the count is lost, the output stays at 0, and
//     counting restarts from 0 after release.
//   - Outputs depend only on registered state; no combinational path from raw to output.
// TESTING
//   1 reset=0 for 3 cycles with all raw=1 -> outputs 0, rise/fall 0.
//     Release at E0 -> ignition/switch/brake =1 after edge E0+17; rise=3'b111 for 1 cycle.
//   2 brake_raw 0->1 clean, others 0 -> brake=1 after edge E0+17; rise=3'b100 for
//     exactly 1 cycle. Then brake_raw->0 -> fall=3'b100 one cycle, brake=0 after 17 edges.
//   3 switch_raw high for 10 cycles then low -> switch stays 0; rise/fall stay 0.
//   4 ignition_raw toggles every cycle for 40 cycles, then holds 1 -> exactly one
//     rise[0] pulse, 17 edges after the final capture edge.
//   5 ignition_raw=1 held; reset pulsed low at cycle 10 of the count -> ignition stays 0.
//     It rises 17 edges after the first post-release capture edge.
//   6 all three raw inputs change on the same edge -> all three outputs flip on the
//     same edge with rise=3'b111. Staggered by 5 cycles -> flips staggered by 5 cycles.

Source files
------------

// File: rtl/pump_input_conditioner_if.sv
// Raw driver contacts in, debounced levels and edge pulses out, for the pump input conditioner.
interface pump_input_conditioner_if;
  logic       ignition_raw;
  logic       switch_raw;
  logic       brake_raw;
  logic       ignition;
  logic       switch;
  logic       brake;
  logic [2:0] rise;
  logic [2:0] fall;

  modport master (
    output ignition_raw, switch_raw, brake_raw,
    input  ignition, switch, brake, rise, fall
  );

  modport slave (
    input  ignition_raw, switch_raw, brake_raw,
    output ignition, switch, brake, rise, fall
  );
endinterface

// File: rtl/pump_input_conditioner.sv
// Synchronises and debounces the ignition, kill-switch and brake inputs of the fuel-pump
// interlock; three independent channels, each with registered level and rise/fall pulses.
module pump_input_conditioner #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input logic                     clock,
  input logic                     reset,
  pump_input_conditioner_if.slave bus
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {StStable, StPending} state_e;

  logic [2:0] raw;
  logic [2:0] level;
  logic [2:0] rise_pulse;
  logic [2:0] fall_pulse;

  // Bit order: [0]=ignition [1]=switch [2]=brake
  assign raw = {bus.brake_raw, bus.switch_raw, bus.ignition_raw};

  assign bus.ignition = level[0];
  assign bus.switch   = level[1];
  assign bus.brake    = level[2];
  assign bus.rise     = rise_pulse;
  assign bus.fall     = fall_pulse;

  for (genvar c = 0; c < 3; c++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q;
    state_e                 state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic                   stable_q, stable_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
      if (!reset) begin
        sync_q   <= '0;
        state_q  <= StStable;
        cnt_q    <= '0;
        stable_q <= 1'b0;
        rise_q   <= 1'b0;
        fall_q   <= 1'b0;
      end else begin
        sync_q   <= {sync_q[SYNC_STAGES-2:0], raw[c]};
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
        rise_q   <= rise_d;
        fall_q   <= fall_d;
      end
    end

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise_d   = 1'b0;
      fall_d   = 1'b0;
      unique case (state_q)
        StStable: begin
          if (s != stable_q) begin
            state_d = StPending;
            cnt_d   = CntW'(1);
          end else begin
            cnt_d = '0;
          end
        end
        StPending: begin
          if (s == stable_q) begin
            state_d = StStable;
            cnt_d   = '0;
          end else if (cnt_q == CntMax) begin
            // Threshold reached: accept the new level and pulse on the same edge
            state_d  = StStable;
            cnt_d    = '0;
            stable_d = s;
            rise_d   = s;
            fall_d   = ~s;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = StStable;
          cnt_d   = '0;
        end
      endcase
    end

    assign level[c]      = stable_q;
    assign rise_pulse[c] = rise_q;
    assign fall_pulse[c] = fall_q;
  end

endmodule

// File: tb/tb_pump_input_conditioner.sv
// Directed bench for pump_input_conditioner: latency, glitch rejection, toggling, reset, stagger.
module tb_pump_input_conditioner;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  pump_input_conditioner_if bus ();

  pump_input_conditioner #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  logic [2:0] lvl;
  assign lvl = {bus.brake, bus.switch, bus.ignition};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next posedge; outputs are sampled 1 time unit after it
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_raw(input logic [2:0] v);
    bus.ignition_raw = v[0];
    bus.switch_raw   = v[1];
    bus.brake_raw    = v[2];
  endtask

  initial begin
    logic       seen;
    int         pulses;
    int         first [3];
    int         t;

    // 1: reset with all raw high, then release
    set_raw(3'b111);
    reset = 1'b0;
    step(3);
    check_eq("rst_level", 32'(lvl), 32'h0);
    check_eq("rst_rise", 32'(bus.rise), 32'h0);
    check_eq("rst_fall", 32'(bus.fall), 32'h0);
    reset = 1'b1;
    step(17);
    check_eq("rel_level_e16", 32'(lvl), 32'h0);
    step(1);
    check_eq("rel_level_e17", 32'(lvl), 32'h7);
    check_eq("rel_rise_e17", 32'(bus.rise), 32'h7);
    step(1);
    check_eq("rel_rise_e18", 32'(bus.rise), 32'h0);
    check_eq("rel_level_e18", 32'(lvl), 32'h7);

    set_raw(3'b000);
    step(18);
    check_eq("all_fall_pulse", 32'(bus.fall), 32'h7);
    check_eq("all_fall_level", 32'(lvl), 32'h0);
    step(1);

    // 2: clean brake press and release
    set_raw(3'b100);
    step(17);
    check_eq("brake_up_e16", 32'(lvl), 32'h0);
    step(1);
    check_eq("brake_up_e17", 32'(lvl), 32'h4);
    check_eq("brake_rise", 32'(bus.rise), 32'h4);
    check_eq("brake_fall_quiet", 32'(bus.fall), 32'h0);
    step(1);
    check_eq("brake_rise_once", 32'(bus.rise), 32'h0);
    set_raw(3'b000);
    step(17);
    check_eq("brake_dn_e16", 32'(lvl), 32'h4);
    check_eq("brake_dn_fall_early", 32'(bus.fall), 32'h0);
    step(1);
    check_eq("brake_dn_e17", 32'(lvl), 32'h0);
    check_eq("brake_fall", 32'(bus.fall), 32'h4);
    step(1);
    check_eq("brake_fall_once", 32'(bus.fall), 32'h0);

    // 3: switch glitch shorter than threshold
    seen = 1'b0;
    bus.switch_raw = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      seen |= bus.switch | (|bus.rise) | (|bus.fall);
    end
    bus.switch_raw = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      seen |= bus.switch | (|bus.rise) | (|bus.fall);
    end
    check_eq("switch_glitch", 32'(seen), 32'h0);

    // 4: ignition toggling every cycle, then held high
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      bus.ignition_raw = ~bus.ignition_raw;
      step(1);
      if (bus.rise[0]) pulses++;
    end
    check_eq("toggle_level", 32'(bus.ignition), 32'h0);
    bus.ignition_raw = 1'b1;
    step(17);
    if (bus.rise[0]) pulses++;
    check_eq("toggle_hold_e16", 32'(bus.ignition), 32'h0);
    step(1);
    if (bus.rise[0]) pulses++;
    check_eq("toggle_hold_e17", 32'(bus.ignition), 32'h1);
    check_eq("toggle_hold_rise", 32'(bus.rise), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (bus.rise[0]) pulses++;
    end
    check_eq("toggle_pulse_count", 32'(pulses), 32'h1);

    // 5: reset mid-count
    bus.ignition_raw = 1'b0;
    step(20);
    check_eq("ign_low_again", 32'(bus.ignition), 32'h0);
    bus.ignition_raw = 1'b1;
    step(10);
    reset = 1'b0;
    step(1);
    check_eq("midrst_level", 32'(lvl), 32'h0);
    reset = 1'b1;
    step(17);
    check_eq("midrst_e16", 32'(bus.ignition), 32'h0);
    step(1);
    check_eq("midrst_e17", 32'(bus.ignition), 32'h1);
    check_eq("midrst_rise", 32'(bus.rise), 32'h1);

    // 6: simultaneous and staggered changes
    bus.ignition_raw = 1'b0;
    step(20);
    set_raw(3'b111);
    step(17);
    check_eq("sim_e16", 32'(lvl), 32'h0);
    step(1);
    check_eq("sim_e17", 32'(lvl), 32'h7);
    check_eq("sim_rise", 32'(bus.rise), 32'h7);
    set_raw(3'b000);
    step(20);
    check_eq("sim_low", 32'(lvl), 32'h0);

    for (int b = 0; b < 3; b++) first[b] = -1;
    bus.ignition_raw = 1'b1;
    step(5);
    bus.switch_raw = 1'b1;
    step(5);
    bus.brake_raw = 1'b1;
    t = 9;
    for (int i = 0; i < 30; i++) begin
      step(1);
      t++;
      for (int b = 0; b < 3; b++) begin
        if (bus.rise[b] && first[b] < 0) first[b] = t;
      end
    end
    check_eq("stag_ign_edge", 32'(first[0]), 32'd17);
    check_eq("stag_sw_edge", 32'(first[1]), 32'd22);
    check_eq("stag_brk_edge", 32'(first[2]), 32'd27);
    check_eq("stag_level", 32'(lvl), 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
